// File: rtl/tjmono_direct_tx.sv
// -----------------------------------------------------------------------------
// tjmono_direct_tx
//
// Chip-side responder for the direct (token/freeze/read) readout interface.
// Hit words from a hit generator are buffered in a small FIFO. TOKEN tells the
// DAQ that a readable word is waiting. Each READ rising edge pops one word and
// shifts it out MSB first on DATA. FREEZE snapshots the current FIFO contents:
// while frozen, only the snapshotted words are readable, and words pushed
// during the freeze become visible when FREEZE drops.
//
// Ports
//   CLK           serial/readout clock; all logic runs on its rising edge
//   RESETB        asynchronous active-low reset
//   HIT_VALID     hit word offered on HIT_DATA
//   HIT_DATA      hit word {col[8:0], row[8:0], le[6:0], te[6:0]}
//   HIT_READY     FIFO can accept a word (registered, 0 while in reset)
//   FREEZE        freeze request from the readout
//   READ          read strobe; each rising edge requests one word
//   TOKEN         a readable hit is available
//   DATA          serial data, MSB first
//   BUSY          a word is being shifted out
//   OVERFLOW_CNT  hits dropped because the FIFO was full (saturating)
//   READ_ERR_CNT  READ edges that were ignored (saturating)
// -----------------------------------------------------------------------------
module tjmono_direct_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RESETB,
    input  logic                  HIT_VALID,
    input  logic [DATA_WIDTH-1:0] HIT_DATA,
    output logic                  HIT_READY,
    input  logic                  FREEZE,
    input  logic                  READ,
    output logic                  TOKEN,
    output logic                  DATA,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  OVERFLOW_CNT,
    output logic [CNT_WIDTH-1:0]  READ_ERR_CNT
);

    // Pointer width, occupancy width (one extra bit so "full" is representable)
    // and bit-counter width.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [OW-1:0] FULL_LVL = OW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q,     rd_ptr_d;
    logic [OW-1:0]         occ_q,        occ_d;
    logic [OW-1:0]         frozen_cnt_q, frozen_cnt_d;
    logic                  frozen_q,     frozen_d;
    logic                  read_dly_q;
    logic                  freeze_dly_q;
    logic                  token_q,      token_d;
    logic                  busy_q,       busy_d;
    logic                  hit_ready_q,  hit_ready_d;
    logic [DATA_WIDTH-1:0] sreg_q,       sreg_d;
    logic [BW-1:0]         bit_cnt_q,    bit_cnt_d;
    state_t                state_q,      state_d;
    logic [CNT_WIDTH-1:0]  ovf_cnt_q,    ovf_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_err_cnt_q, rd_err_cnt_d;

    // -------------------------------------------------------------------------
    // Edge detection and handshake decode
    // -------------------------------------------------------------------------
    logic rise_rd;
    logic rise_fz;
    logic fall_fz;
    logic full;
    logic push;
    logic pop;

    assign rise_rd = READ & ~read_dly_q;
    assign rise_fz = FREEZE & ~freeze_dly_q;
    assign fall_fz = ~FREEZE & freeze_dly_q;
    assign full    = (occ_q == FULL_LVL);

    // HIT_READY is a registered !full, so a pop in this cycle cannot make
    // room for a push in the same cycle.
    assign push    = HIT_VALID & hit_ready_q;

    // A READ edge is served only from IDLE and only if TOKEN was already set
    // before this edge; TOKEN already accounts for the freeze snapshot.
    assign pop     = (state_q == IDLE) & rise_rd & token_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        frozen_cnt_d = frozen_cnt_q;
        frozen_d     = frozen_q;
        token_d      = token_q;
        busy_d       = busy_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        state_d      = state_q;
        ovf_cnt_d    = ovf_cnt_q;
        rd_err_cnt_d = rd_err_cnt_q;
        hit_ready_d  = hit_ready_q;

        // FIFO pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        // Snapshot: the word popped on the freeze edge has already left, and
        // a word pushed on the same edge arrives after the snapshot.
        if (rise_fz) begin
            frozen_d     = 1'b1;
            frozen_cnt_d = occ_q - OW'(pop);
        end else begin
            if (fall_fz) begin
                frozen_d = 1'b0;
            end
            if (frozen_q && pop && (frozen_cnt_q != '0)) begin
                frozen_cnt_d = frozen_cnt_q - OW'(1);
            end
        end

        // TOKEN reflects what is readable after this edge.
        token_d     = frozen_d ? (frozen_cnt_d != '0) : (occ_d != '0);
        hit_ready_d = (occ_d != FULL_LVL);

        // Serialiser. DATA is the MSB of sreg; sreg is cleared on return to
        // IDLE so DATA idles low.
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SHIFT;
                    sreg_d    = mem[rd_ptr_q];
                    bit_cnt_d = LAST_BIT;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                    sreg_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    sreg_d    = sreg_q << 1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Error counters saturate at all-ones.
        if (HIT_VALID && full && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
        end
        if (rise_rd && !pop && (rd_err_cnt_q != '1)) begin
            rd_err_cnt_d = rd_err_cnt_q + CNT_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            frozen_cnt_q <= '0;
            frozen_q     <= 1'b0;
            read_dly_q   <= 1'b0;
            freeze_dly_q <= 1'b0;
            token_q      <= 1'b0;
            busy_q       <= 1'b0;
            hit_ready_q  <= 1'b0;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            ovf_cnt_q    <= '0;
            rd_err_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            frozen_cnt_q <= frozen_cnt_d;
            frozen_q     <= frozen_d;
            read_dly_q   <= READ;
            freeze_dly_q <= FREEZE;
            token_q      <= token_d;
            busy_q       <= busy_d;
            hit_ready_q  <= hit_ready_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            state_q      <= state_d;
            ovf_cnt_q    <= ovf_cnt_d;
            rd_err_cnt_q <= rd_err_cnt_d;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and occupancy define
    // which entries are valid, so stale contents are never read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= HIT_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign HIT_READY    = hit_ready_q;
    assign TOKEN        = token_q;
    assign DATA         = sreg_q[DATA_WIDTH-1];
    assign BUSY         = busy_q;
    assign OVERFLOW_CNT = ovf_cnt_q;
    assign READ_ERR_CNT = rd_err_cnt_q;

endmodule

// File: tb/tb_tjmono_direct_tx.sv
// -----------------------------------------------------------------------------
// tb_tjmono_direct_tx
//
// Directed bench for tjmono_direct_tx with default parameters (32-bit words,
// 16-deep FIFO, 8-bit counters). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_tjmono_direct_tx;

    localparam int W = 32;
    localparam int C = 8;

    logic         CLK       = 1'b0;
    logic         RESETB    = 1'b0;
    logic         HIT_VALID = 1'b0;
    logic [W-1:0] HIT_DATA  = '0;
    logic         FREEZE    = 1'b0;
    logic         READ      = 1'b0;
    logic         HIT_READY;
    logic         TOKEN;
    logic         DATA;
    logic         BUSY;
    logic [C-1:0] OVERFLOW_CNT;
    logic [C-1:0] READ_ERR_CNT;

    int errors = 0;
    int checks = 0;

    tjmono_direct_tx #(
        .DATA_WIDTH (W),
        .DEPTH      (16),
        .CNT_WIDTH  (C)
    ) dut (
        .CLK          (CLK),
        .RESETB       (RESETB),
        .HIT_VALID    (HIT_VALID),
        .HIT_DATA     (HIT_DATA),
        .HIT_READY    (HIT_READY),
        .FREEZE       (FREEZE),
        .READ         (READ),
        .TOKEN        (TOKEN),
        .DATA         (DATA),
        .BUSY         (BUSY),
        .OVERFLOW_CNT (OVERFLOW_CNT),
        .READ_ERR_CNT (READ_ERR_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        HIT_DATA  = w;
        HIT_VALID = 1'b1;
        tick();
        HIT_VALID = 1'b0;
    endtask

    // Pulses READ for one cycle and collects the W serial bits that follow.
    // extra_at >= 0 raises READ again after that many bits have been sampled.
    task automatic read_word(input int extra_at, output logic [W-1:0] w,
                             output int busy_miss);
        busy_miss = 0;
        w         = '0;
        READ      = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            READ         = (i == extra_at);
            w[W-1-i]     = DATA;
            if (BUSY !== 1'b1) busy_miss++;
            tick();
        end
        READ = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        #2;
        checks++; if (HIT_READY !== 1'b0) begin errors++; $display("FAIL reset_hit_ready: got %b want 0", HIT_READY); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL reset_token: got %b want 0", TOKEN); end
        checks++; if (DATA !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (OVERFLOW_CNT !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d want 0", OVERFLOW_CNT); end
        checks++; if (READ_ERR_CNT !== 8'd0) begin errors++; $display("FAIL reset_rderr: got %0d want 0", READ_ERR_CNT); end
        tick();
        tick();
        RESETB = 1'b1;
        tick();
        checks++; if (HIT_READY !== 1'b1) begin errors++; $display("FAIL release_hit_ready: got %b want 1", HIT_READY); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL release_token: got %b want 0", TOKEN); end
    endtask

    task automatic test_single();
        logic [W-1:0] w;
        int           bm;
        push_word(32'hA5A5_0001);
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL single_token_after_push: got %b want 1", TOKEN); end
        checks++; if (HIT_READY !== 1'b1) begin errors++; $display("FAIL single_hit_ready: got %b want 1", HIT_READY); end
        read_word(-1, w, bm);
        checks++; if (w !== 32'hA5A5_0001) begin errors++; $display("FAIL single_word: got %h want a5a50001", w); end
        checks++; if (bm !== 0) begin errors++; $display("FAIL single_busy: %0d of 32 bit slots had BUSY low, want 0", bm); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL single_token_after: got %b want 0", TOKEN); end
        checks++; if (DATA !== 1'b0) begin errors++; $display("FAIL single_data_idle: got %b want 0", DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", BUSY); end
    endtask

    task automatic test_freeze();
        logic [W-1:0] w;
        int           bm;
        for (int i = 1; i <= 3; i++) push_word(32'h1111_0000 + W'(i));
        FREEZE = 1'b1;
        tick();
        for (int i = 4; i <= 5; i++) push_word(32'h1111_0000 + W'(i));
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL freeze_token_start: got %b want 1", TOKEN); end
        for (int i = 1; i <= 3; i++) begin
            read_word(-1, w, bm);
            checks++; if (w !== 32'h1111_0000 + W'(i)) begin errors++; $display("FAIL freeze_word%0d: got %h want %h", i, w, 32'h1111_0000 + W'(i)); end
        end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL freeze_token_drained: got %b want 0", TOKEN); end
        FREEZE = 1'b0;
        tick();
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL unfreeze_token: got %b want 1", TOKEN); end
        for (int i = 4; i <= 5; i++) begin
            read_word(-1, w, bm);
            checks++; if (w !== 32'h1111_0000 + W'(i)) begin errors++; $display("FAIL unfreeze_word%0d: got %h want %h", i, w, 32'h1111_0000 + W'(i)); end
        end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL freeze_token_end: got %b want 0", TOKEN); end
        checks++; if (READ_ERR_CNT !== 8'd0) begin errors++; $display("FAIL freeze_rderr: got %0d want 0", READ_ERR_CNT); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] w;
        int           bm;
        for (int i = 0; i < 16; i++) push_word(32'hC000_0000 + W'(i));
        checks++; if (HIT_READY !== 1'b0) begin errors++; $display("FAIL full_hit_ready: got %b want 0", HIT_READY); end
        checks++; if (OVERFLOW_CNT !== 8'd0) begin errors++; $display("FAIL full_ovf0: got %0d want 0", OVERFLOW_CNT); end
        push_word(32'hC000_0010);
        checks++; if (OVERFLOW_CNT !== 8'd1) begin errors++; $display("FAIL full_ovf1: got %0d want 1", OVERFLOW_CNT); end
        // Read and push on the same edge while full: the push is still dropped.
        HIT_DATA  = 32'hDEAD_BEEF;
        HIT_VALID = 1'b1;
        READ      = 1'b1;
        tick();
        HIT_VALID = 1'b0;
        READ      = 1'b0;
        w = '0;
        for (int i = 0; i < W; i++) begin
            w[W-1-i] = DATA;
            tick();
        end
        checks++; if (OVERFLOW_CNT !== 8'd2) begin errors++; $display("FAIL full_ovf2: got %0d want 2", OVERFLOW_CNT); end
        checks++; if (w !== 32'hC000_0000) begin errors++; $display("FAIL full_pop_word: got %h want c0000000", w); end
        checks++; if (HIT_READY !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b want 1", HIT_READY); end
        for (int i = 1; i < 16; i++) begin
            read_word(-1, w, bm);
            checks++; if (w !== 32'hC000_0000 + W'(i)) begin errors++; $display("FAIL drain_word%0d: got %h want %h", i, w, 32'hC000_0000 + W'(i)); end
        end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL drain_token: got %b want 0", TOKEN); end
    endtask

    task automatic test_read_err();
        logic [W-1:0] w;
        int           bm;
        READ = 1'b1;
        tick();
        READ = 1'b0;
        tick();
        checks++; if (READ_ERR_CNT !== 8'd1) begin errors++; $display("FAIL rderr_empty: got %0d want 1", READ_ERR_CNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rderr_empty_busy: got %b want 0", BUSY); end
        push_word(32'hB00B_0001);
        push_word(32'hB00B_0002);
        read_word(4, w, bm);
        checks++; if (w !== 32'hB00B_0001) begin errors++; $display("FAIL rderr_shift_word: got %h want b00b0001", w); end
        checks++; if (bm !== 0) begin errors++; $display("FAIL rderr_shift_busy: %0d slots had BUSY low, want 0", bm); end
        checks++; if (READ_ERR_CNT !== 8'd2) begin errors++; $display("FAIL rderr_shift: got %0d want 2", READ_ERR_CNT); end
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL rderr_token: got %b want 1", TOKEN); end
        read_word(-1, w, bm);
        checks++; if (w !== 32'hB00B_0002) begin errors++; $display("FAIL rderr_second_word: got %h want b00b0002", w); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL rderr_token_end: got %b want 0", TOKEN); end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] w;
        int           bm;
        push_word(32'hFFFF_FFFF);
        for (int i = 1; i <= 3; i++) push_word(32'hD000_0000 + W'(i));
        READ = 1'b1;
        tick();
        READ = 1'b0;
        repeat (10) tick();
        checks++; if ({BUSY, DATA} !== 2'b11) begin errors++; $display("FAIL midreset_pre: got busy,data=%b want 11", {BUSY, DATA}); end
        RESETB = 1'b0;
        #1;
        checks++; if (DATA !== 1'b0) begin errors++; $display("FAIL midreset_data: got %b want 0", DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL midreset_token: got %b want 0", TOKEN); end
        checks++; if (HIT_READY !== 1'b0) begin errors++; $display("FAIL midreset_hit_ready: got %b want 0", HIT_READY); end
        checks++; if (OVERFLOW_CNT !== 8'd0) begin errors++; $display("FAIL midreset_ovf: got %0d want 0", OVERFLOW_CNT); end
        checks++; if (READ_ERR_CNT !== 8'd0) begin errors++; $display("FAIL midreset_rderr: got %0d want 0", READ_ERR_CNT); end
        tick();
        tick();
        RESETB = 1'b1;
        tick();
        checks++; if (HIT_READY !== 1'b1) begin errors++; $display("FAIL midreset_release_ready: got %b want 1", HIT_READY); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL midreset_release_token: got %b want 0", TOKEN); end
        push_word(32'hE000_0005);
        read_word(-1, w, bm);
        checks++; if (w !== 32'hE000_0005) begin errors++; $display("FAIL midreset_fifo_empty: got %h want e0000005", w); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL midreset_token_end: got %b want 0", TOKEN); end
    endtask

    task automatic test_freeze_read_same();
        logic [W-1:0] w;
        int           bm;
        push_word(32'hF000_0001);
        push_word(32'hF000_0002);
        FREEZE = 1'b1;
        read_word(-1, w, bm);
        checks++; if (w !== 32'hF000_0001) begin errors++; $display("FAIL same_word1: got %h want f0000001", w); end
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL same_token: got %b want 1", TOKEN); end
        read_word(-1, w, bm);
        checks++; if (w !== 32'hF000_0002) begin errors++; $display("FAIL same_word2: got %h want f0000002", w); end
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL same_token_drained: got %b want 0", TOKEN); end
        push_word(32'hF000_0003);
        checks++; if (TOKEN !== 1'b0) begin errors++; $display("FAIL same_token_frozen_push: got %b want 0", TOKEN); end
        FREEZE = 1'b0;
        tick();
        checks++; if (TOKEN !== 1'b1) begin errors++; $display("FAIL same_token_unfreeze: got %b want 1", TOKEN); end
        read_word(-1, w, bm);
        checks++; if (w !== 32'hF000_0003) begin errors++; $display("FAIL same_word3: got %h want f0000003", w); end
        checks++; if (READ_ERR_CNT !== 8'd0) begin errors++; $display("FAIL same_rderr: got %0d want 0", READ_ERR_CNT); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_freeze();
        test_overflow();
        test_read_err();
        test_reset_mid_shift();
        test_freeze_read_same();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
